// File: rtl/game_pkg.sv
// Shared game types: tile and direction codes, mover FSM states and
// the board-map coordinate-to-address helper.
package game_pkg;

    typedef logic [2:0] tile_t;
    typedef logic [2:0] dir_t;

    localparam tile_t TILE   = 3'b000;
    localparam tile_t PLAYER = 3'b001;
    localparam tile_t WALL   = 3'b010;
    localparam tile_t BLOCK  = 3'b011;

    localparam dir_t DIR_IDLE  = 3'b000;
    localparam dir_t DIR_UP    = 3'b001;
    localparam dir_t DIR_RIGHT = 3'b010;
    localparam dir_t DIR_DOWN  = 3'b011;
    localparam dir_t DIR_LEFT  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_REJECT = 3'd2,
        ST_WR_OLD = 3'd3,
        ST_WR_NEW = 3'd4,
        ST_UPDATE = 3'd5
    } mover_state_e;

    function automatic logic dir_is_move(input dir_t d);
        return (d >= DIR_UP) && (d <= DIR_LEFT);
    endfunction

    // Row-major address; callers truncate to their RAM address width.
    function automatic int coord_to_addr(input int x, input int y, input int grid_w);
        return y * grid_w + x;
    endfunction

endpackage

// File: rtl/grid_step.sv
// One-cell step on the board: next coordinate for a direction, an
// off-grid flag (no wrap-around) and the map address of the current cell.
module grid_step
    import game_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12,
    parameter int XW     = 4,
    parameter int YW     = 4,
    parameter int ADDR_W = 8
) (
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    input  dir_t              dir,
    output logic [XW-1:0]     nx,
    output logic [YW-1:0]     ny,
    output logic              oob,
    output logic [ADDR_W-1:0] addr
);

    int addr_full_s;

    // Neighbour coordinate and edge detection for the requested direction.
    always_comb begin
        nx  = x;
        ny  = y;
        oob = 1'b0;
        case (dir)
            DIR_UP: begin
                if (y == YW'(0)) oob = 1'b1;
                else             ny  = y - YW'(1);
            end
            DIR_DOWN: begin
                if (y == YW'(GRID_H - 1)) oob = 1'b1;
                else                      ny  = y + YW'(1);
            end
            DIR_LEFT: begin
                if (x == XW'(0)) oob = 1'b1;
                else             nx  = x - XW'(1);
            end
            DIR_RIGHT: begin
                if (x == XW'(GRID_W - 1)) oob = 1'b1;
                else                      nx  = x + XW'(1);
            end
            default: begin
                nx  = x;
                ny  = y;
                oob = 1'b0;
            end
        endcase
    end

    // Address of the cell currently addressed by x/y.
    always_comb begin
        addr_full_s = coord_to_addr(int'(x), int'(y), GRID_W);
    end

    assign addr = addr_full_s[ADDR_W-1:0];

endmodule

// File: rtl/player_mover.sv
// Applies an accepted move to the board map (clear old cell, set new cell)
// and then commits the new player coordinates and the saturating move count.
module player_mover
    import game_pkg::*;
#(
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 12,
    parameter int XW      = 4,
    parameter int YW      = 4,
    parameter int ADDR_W  = 8,
    parameter int START_X = 5,
    parameter int START_Y = 5,
    parameter int CNT_W   = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ld,
    input  dir_t              dir,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output tile_t             wr_data,
    input  logic              wr_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [XW-1:0]     player_x,
    output logic [YW-1:0]     player_y,
    output logic [CNT_W-1:0]  move_count
);

    if (GRID_W * GRID_H > (1 << ADDR_W)) begin : g_addr_check
        $error("player_mover: GRID_W*GRID_H does not fit in ADDR_W address bits");
    end

    mover_state_e      state_r, state_next_s;
    dir_t              dir_q_r;
    logic [XW-1:0]     nx_r, px_r, step_nx_s;
    logic [YW-1:0]     ny_r, py_r, step_ny_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              step_oob_s;
    logic [ADDR_W-1:0] cur_addr_s, new_addr_s;
    int                new_addr_full_s;

    logic              wr_en_r, wr_en_next_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_next_s;
    tile_t             wr_data_r, wr_data_next_s;
    logic              busy_r, busy_next_s;
    logic              done_r, done_next_s;
    logic              err_r, err_next_s;

    grid_step #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .XW     (XW),
        .YW     (YW),
        .ADDR_W (ADDR_W)
    ) u_grid_step (
        .x    (px_r),
        .y    (py_r),
        .dir  (dir_q_r),
        .nx   (step_nx_s),
        .ny   (step_ny_s),
        .oob  (step_oob_s),
        .addr (cur_addr_s)
    );

    // Map address of the latched destination cell.
    always_comb begin
        new_addr_full_s = coord_to_addr(int'(nx_r), int'(ny_r), GRID_W);
    end

    assign new_addr_s = new_addr_full_s[ADDR_W-1:0];

    // Next state, then the Moore outputs of that state so they can be registered.
    always_comb begin
        state_next_s   = state_r;
        wr_en_next_s   = 1'b0;
        wr_addr_next_s = {ADDR_W{1'b0}};
        wr_data_next_s = TILE;
        busy_next_s    = 1'b0;
        done_next_s    = 1'b0;
        err_next_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (ld && dir_is_move(dir)) state_next_s = ST_CALC;
                else                        state_next_s = ST_IDLE;
            end
            ST_CALC: begin
                if (step_oob_s) state_next_s = ST_REJECT;
                else            state_next_s = ST_WR_OLD;
            end
            ST_REJECT: state_next_s = ST_IDLE;
            ST_WR_OLD: begin
                if (wr_ack) state_next_s = ST_WR_NEW;
                else        state_next_s = ST_WR_OLD;
            end
            ST_WR_NEW: begin
                if (wr_ack) state_next_s = ST_UPDATE;
                else        state_next_s = ST_WR_NEW;
            end
            ST_UPDATE: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase

        // Player position is stable until UPDATE, so cur_addr_s is the old cell.
        case (state_next_s)
            ST_IDLE: busy_next_s = 1'b0;
            ST_CALC: busy_next_s = 1'b1;
            ST_REJECT: begin
                busy_next_s = 1'b1;
                err_next_s  = 1'b1;
            end
            ST_WR_OLD: begin
                busy_next_s    = 1'b1;
                wr_en_next_s   = 1'b1;
                wr_addr_next_s = cur_addr_s;
                wr_data_next_s = TILE;
            end
            ST_WR_NEW: begin
                busy_next_s    = 1'b1;
                wr_en_next_s   = 1'b1;
                wr_addr_next_s = new_addr_s;
                wr_data_next_s = PLAYER;
            end
            ST_UPDATE: begin
                busy_next_s = 1'b1;
                done_next_s = 1'b1;
            end
            default: busy_next_s = 1'b0;
        endcase
    end

    // State, latched move operands, player position, counter and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            dir_q_r   <= DIR_IDLE;
            nx_r      <= XW'(START_X);
            ny_r      <= YW'(START_Y);
            px_r      <= XW'(START_X);
            py_r      <= YW'(START_Y);
            cnt_r     <= {CNT_W{1'b0}};
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= TILE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            wr_en_r   <= wr_en_next_s;
            wr_addr_r <= wr_addr_next_s;
            wr_data_r <= wr_data_next_s;
            busy_r    <= busy_next_s;
            done_r    <= done_next_s;
            err_r     <= err_next_s;
            if (state_r == ST_IDLE && state_next_s == ST_CALC) begin
                dir_q_r <= dir;
            end
            if (state_r == ST_CALC) begin
                nx_r <= step_nx_s;
                ny_r <= step_ny_s;
            end
            if (state_r == ST_UPDATE) begin
                px_r <= nx_r;
                py_r <= ny_r;
                if (cnt_r != {CNT_W{1'b1}}) cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign player_x   = px_r;
    assign player_y   = py_r;
    assign move_count = cnt_r;

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover: default instance, a corner-start instance
// at (0,0) and a 2-bit counter instance for saturation.
module tb_player_mover;

    logic clk;
    logic resetn;

    logic       d_ld, d_ack, d_wr_en, d_busy, d_done, d_err;
    logic [2:0] d_dir, d_wr_data;
    logic [7:0] d_wr_addr;
    logic [3:0] d_x, d_y;
    logic [9:0] d_cnt;

    logic       c_ld, c_ack, c_wr_en, c_busy, c_done, c_err;
    logic [2:0] c_dir, c_wr_data;
    logic [7:0] c_wr_addr;
    logic [3:0] c_x, c_y;
    logic [9:0] c_cnt;
    logic       c_wr_seen;

    logic       s_ld, s_ack, s_wr_en, s_busy, s_done, s_err;
    logic [2:0] s_dir, s_wr_data;
    logic [7:0] s_wr_addr;
    logic [3:0] s_x, s_y;
    logic [1:0] s_cnt;

    int vectors    = 0;
    int miscompares = 0;
    int wr_cycles;
    int done_cycles;

    player_mover u_dut (
        .clk(clk), .resetn(resetn), .ld(d_ld), .dir(d_dir),
        .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_data(d_wr_data), .wr_ack(d_ack),
        .busy(d_busy), .done(d_done), .err(d_err),
        .player_x(d_x), .player_y(d_y), .move_count(d_cnt)
    );

    player_mover #(.START_X(0), .START_Y(0)) u_corner (
        .clk(clk), .resetn(resetn), .ld(c_ld), .dir(c_dir),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data), .wr_ack(c_ack),
        .busy(c_busy), .done(c_done), .err(c_err),
        .player_x(c_x), .player_y(c_y), .move_count(c_cnt)
    );

    player_mover #(.CNT_W(2)) u_sat (
        .clk(clk), .resetn(resetn), .ld(s_ld), .dir(s_dir),
        .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_ack(s_ack),
        .busy(s_busy), .done(s_done), .err(s_err),
        .player_x(s_x), .player_y(s_y), .move_count(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sticky record of any write request from the corner instance after reset.
    always @(posedge clk) begin
        if (!resetn) c_wr_seen <= 1'b0;
        else         c_wr_seen <= c_wr_seen | c_wr_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0;
        d_ld = 1'b0; d_dir = 3'd0; d_ack = 1'b0;
        c_ld = 1'b0; c_dir = 3'd0; c_ack = 1'b1;
        s_ld = 1'b0; s_dir = 3'd0; s_ack = 1'b1;
        tick();
        tick();

        // 1: reset state
        chk("rst_x", 32'(d_x), 32'd5);
        chk("rst_y", 32'(d_y), 32'd5);
        chk("rst_cnt", 32'(d_cnt), 32'd0);
        chk("rst_wr_en", 32'(d_wr_en), 32'd0);
        chk("rst_busy", 32'(d_busy), 32'd0);
        chk("rst_done", 32'(d_done), 32'd0);
        chk("rst_err", 32'(d_err), 32'd0);
        chk("rst_addr", 32'(d_wr_addr), 32'd0);
        resetn = 1'b1;

        // 2: move right from (5,5), ack tied high
        d_ack = 1'b1; d_ld = 1'b1; d_dir = 3'b010;
        tick();
        d_ld = 1'b0; d_dir = 3'b000;
        chk("t2_c1_busy", 32'(d_busy), 32'd1);
        chk("t2_c1_wr_en", 32'(d_wr_en), 32'd0);
        tick();
        chk("t2_c2_wr_en", 32'(d_wr_en), 32'd1);
        chk("t2_c2_addr", 32'(d_wr_addr), 32'd85);
        chk("t2_c2_data", 32'(d_wr_data), 32'd0);
        tick();
        chk("t2_c3_wr_en", 32'(d_wr_en), 32'd1);
        chk("t2_c3_addr", 32'(d_wr_addr), 32'd86);
        chk("t2_c3_data", 32'(d_wr_data), 32'd1);
        tick();
        chk("t2_c4_done", 32'(d_done), 32'd1);
        chk("t2_c4_wr_en", 32'(d_wr_en), 32'd0);
        tick();
        chk("t2_c5_x", 32'(d_x), 32'd6);
        chk("t2_c5_cnt", 32'(d_cnt), 32'd1);
        chk("t2_c5_busy", 32'(d_busy), 32'd0);
        chk("t2_c5_done", 32'(d_done), 32'd0);

        // 3: ack withheld for three edges in WR_OLD, from (6,5)
        d_ack = 1'b0; d_ld = 1'b1; d_dir = 3'b010;
        tick();
        d_ld = 1'b0; d_dir = 3'b000;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t3_hold_wr_en", 32'(d_wr_en), 32'd1);
            chk("t3_hold_addr", 32'(d_wr_addr), 32'd86);
            chk("t3_hold_data", 32'(d_wr_data), 32'd0);
            if (k == 3) d_ack = 1'b1;
            tick();
        end
        chk("t3_c6_addr", 32'(d_wr_addr), 32'd87);
        chk("t3_c6_data", 32'(d_wr_data), 32'd1);
        tick();
        chk("t3_c7_done", 32'(d_done), 32'd1);
        tick();
        chk("t3_c8_x", 32'(d_x), 32'd7);
        chk("t3_c8_cnt", 32'(d_cnt), 32'd2);

        // 5: move down from (7,5) while hammering ld, then invalid dirs in IDLE
        d_ld = 1'b1; d_dir = 3'b011;
        tick();
        wr_cycles = 0;
        done_cycles = 0;
        for (int c = 1; c <= 9; c++) begin
            if (d_wr_en) wr_cycles++;
            if (d_done) done_cycles++;
            if (c == 3) chk("t5_new_addr", 32'(d_wr_addr), 32'd103);
            if (c <= 4) begin
                d_ld = 1'b1; d_dir = 3'((c % 4) + 1);
            end else if (c == 5) begin
                d_ld = 1'b1; d_dir = 3'b000;
            end else if (c == 6) begin
                d_ld = 1'b1; d_dir = 3'b111;
            end else begin
                d_ld = 1'b0; d_dir = 3'b000;
            end
            tick();
        end
        chk("t5_wr_cycles", 32'(wr_cycles), 32'd2);
        chk("t5_done_cycles", 32'(done_cycles), 32'd1);
        chk("t5_busy", 32'(d_busy), 32'd0);
        chk("t5_x", 32'(d_x), 32'd7);
        chk("t5_y", 32'(d_y), 32'd6);
        chk("t5_cnt", 32'(d_cnt), 32'd3);

        // 6a: reset asserted while in WR_NEW of a left move from (7,6)
        d_ack = 1'b1; d_ld = 1'b1; d_dir = 3'b100;
        tick();
        d_ld = 1'b0; d_dir = 3'b000;
        tick();
        tick();
        chk("t6_wrnew_addr", 32'(d_wr_addr), 32'd102);
        chk("t6_wrnew_data", 32'(d_wr_data), 32'd1);
        resetn = 1'b0;
        tick();
        chk("t6_rst_wr_en", 32'(d_wr_en), 32'd0);
        chk("t6_rst_busy", 32'(d_busy), 32'd0);
        chk("t6_rst_x", 32'(d_x), 32'd5);
        chk("t6_rst_y", 32'(d_y), 32'd5);
        chk("t6_rst_cnt", 32'(d_cnt), 32'd0);
        resetn = 1'b1;
        tick();
        chk("t6_after_wr_en", 32'(d_wr_en), 32'd0);
        chk("t6_after_done", 32'(d_done), 32'd0);

        // 4: off-grid requests at the (0,0) corner
        c_ld = 1'b1; c_dir = 3'b001;
        tick();
        c_ld = 1'b0; c_dir = 3'b000;
        chk("t4_up_c1_busy", 32'(c_busy), 32'd1);
        tick();
        chk("t4_up_c2_err", 32'(c_err), 32'd1);
        tick();
        chk("t4_up_c3_err", 32'(c_err), 32'd0);
        chk("t4_up_c3_busy", 32'(c_busy), 32'd0);
        c_ld = 1'b1; c_dir = 3'b100;
        tick();
        c_ld = 1'b0; c_dir = 3'b000;
        tick();
        chk("t4_left_c2_err", 32'(c_err), 32'd1);
        chk("t4_left_c2_done", 32'(c_done), 32'd0);
        tick();
        chk("t4_left_c3_err", 32'(c_err), 32'd0);
        tick();
        chk("t4_wr_seen", 32'(c_wr_seen), 32'd0);
        chk("t4_x", 32'(c_x), 32'd0);
        chk("t4_y", 32'(c_y), 32'd0);
        chk("t4_cnt", 32'(c_cnt), 32'd0);

        // 6b: 2-bit counter saturates after five good moves
        for (int m = 1; m <= 5; m++) begin
            s_ld = 1'b1;
            s_dir = (m % 2 == 1) ? 3'b010 : 3'b100;
            tick();
            s_ld = 1'b0; s_dir = 3'b000;
            for (int w = 0; w < 4; w++) tick();
            if (m == 1) chk("t6_sat_cnt1", 32'(s_cnt), 32'd1);
            if (m == 3) chk("t6_sat_cnt3", 32'(s_cnt), 32'd3);
        end
        chk("t6_sat_cnt5", 32'(s_cnt), 32'd3);
        chk("t6_sat_x", 32'(s_x), 32'd6);
        chk("t6_sat_busy", 32'(s_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
